// File: rtl/dmem_arb_pkg.sv
// Shared definitions for the data-memory arbiter: sequencer state encoding
// and default memory geometry.
package dmem_arb_pkg;

    localparam int DEF_ADDR_W = 6;
    localparam int DEF_DATA_W = 32;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } arb_state_t;

endpackage

// File: rtl/rr_pick2.sv
// Combinational two-way round-robin chooser: on contention the requester
// that did not win last time is picked.
module rr_pick2 (
    input  logic [1:0] req,
    input  logic       last_grant,
    output logic       valid,
    output logic       winner
);

    always_comb begin
        valid  = |req;
        winner = (req == 2'b11) ? ~last_grant : req[1];
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Arbiter sharing the single-port data memory between the CPU (requester 0)
// and the debug/DMA loader (requester 1), one access per three cycles.
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              r0_req,
    input  logic              r0_we,
    input  logic [ADDR_W-1:0] r0_addr,
    input  logic [DATA_W-1:0] r0_wdata,
    output logic              r0_ack,
    output logic [DATA_W-1:0] r0_rdata,
    input  logic              r1_req,
    input  logic              r1_we,
    input  logic [ADDR_W-1:0] r1_addr,
    input  logic [DATA_W-1:0] r1_wdata,
    output logic              r1_ack,
    output logic [DATA_W-1:0] r1_rdata,
    output logic              mem_cs,
    output logic              mem_r,
    output logic              mem_w,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    arb_state_t        state;
    arb_state_t        state_nxt;
    logic              last_grant;
    logic              last_grant_nxt;
    logic              grant_id;
    logic              grant_id_nxt;
    logic              pick_valid;
    logic              pick_winner;
    logic              mem_cs_nxt;
    logic              mem_r_nxt;
    logic              mem_w_nxt;
    logic [ADDR_W-1:0] mem_addr_nxt;
    logic [DATA_W-1:0] mem_wdata_nxt;
    logic              r0_ack_nxt;
    logic              r1_ack_nxt;
    logic [DATA_W-1:0] r0_rdata_nxt;
    logic [DATA_W-1:0] r1_rdata_nxt;

    rr_pick2 u_pick (
        .req        ({r1_req, r0_req}),
        .last_grant (last_grant),
        .valid      (pick_valid),
        .winner     (pick_winner)
    );

    // last_grant resets to 1 so that requester 0 wins the first contention.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            last_grant <= 1'b1;
            grant_id   <= 1'b0;
            mem_cs     <= 1'b0;
            mem_r      <= 1'b0;
            mem_w      <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            r0_ack     <= 1'b0;
            r1_ack     <= 1'b0;
            r0_rdata   <= '0;
            r1_rdata   <= '0;
        end else begin
            state      <= state_nxt;
            last_grant <= last_grant_nxt;
            grant_id   <= grant_id_nxt;
            mem_cs     <= mem_cs_nxt;
            mem_r      <= mem_r_nxt;
            mem_w      <= mem_w_nxt;
            mem_addr   <= mem_addr_nxt;
            mem_wdata  <= mem_wdata_nxt;
            r0_ack     <= r0_ack_nxt;
            r1_ack     <= r1_ack_nxt;
            r0_rdata   <= r0_rdata_nxt;
            r1_rdata   <= r1_rdata_nxt;
        end
    end

    always_comb begin
        state_nxt = IDLE;
        unique case (state)
            IDLE:    state_nxt = pick_valid ? ACCESS : IDLE;
            ACCESS:  state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Address and write data hold their last value once the access closes;
    // read data is captured only on reads so a floating bus never leaks out.
    always_comb begin
        last_grant_nxt = last_grant;
        grant_id_nxt   = grant_id;
        mem_cs_nxt     = mem_cs;
        mem_r_nxt      = mem_r;
        mem_w_nxt      = mem_w;
        mem_addr_nxt   = mem_addr;
        mem_wdata_nxt  = mem_wdata;
        r0_ack_nxt     = 1'b0;
        r1_ack_nxt     = 1'b0;
        r0_rdata_nxt   = r0_rdata;
        r1_rdata_nxt   = r1_rdata;
        unique case (state)
            IDLE: begin
                mem_cs_nxt = 1'b0;
                mem_r_nxt  = 1'b0;
                mem_w_nxt  = 1'b0;
                if (pick_valid) begin
                    grant_id_nxt   = pick_winner;
                    last_grant_nxt = pick_winner;
                    mem_cs_nxt     = 1'b1;
                    mem_w_nxt      = pick_winner ? r1_we : r0_we;
                    mem_r_nxt      = pick_winner ? ~r1_we : ~r0_we;
                    mem_addr_nxt   = pick_winner ? r1_addr : r0_addr;
                    mem_wdata_nxt  = pick_winner ? r1_wdata : r0_wdata;
                end
            end
            ACCESS: begin
                mem_cs_nxt = 1'b0;
                mem_r_nxt  = 1'b0;
                mem_w_nxt  = 1'b0;
                if (grant_id) begin
                    r1_ack_nxt = 1'b1;
                    if (mem_r) r1_rdata_nxt = mem_rdata;
                end else begin
                    r0_ack_nxt = 1'b1;
                    if (mem_r) r0_rdata_nxt = mem_rdata;
                end
            end
            DONE: begin
                mem_cs_nxt = 1'b0;
                mem_r_nxt  = 1'b0;
                mem_w_nxt  = 1'b0;
            end
            default: begin
                mem_cs_nxt = 1'b0;
                mem_r_nxt  = 1'b0;
                mem_w_nxt  = 1'b0;
            end
        endcase
    end

endmodule
